// File: rtl/proj_pkg.sv
// Shared types and screen bounds for the projectile slot table and its renderer.
package proj_pkg;

  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef struct packed {
    logic       active;
    logic       dir;
    logic [9:0] x;
    logic [9:0] y;
  } proj_slot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/projectile_scheduler_if.sv
// Fire request/acknowledge bundle between the two turrets and the scheduler.
// Handshake: req rises and holds until ack; ack is a one-cycle pulse; req must fall
// the cycle after ack, and a req still high two cycles after ack is a fresh request.
interface projectile_scheduler_if;
  logic fire_l_req;
  logic fire_r_req;
  logic fire_l_ack;
  logic fire_r_ack;

  modport master (output fire_l_req, fire_r_req, input fire_l_ack, fire_r_ack);
  modport slave  (input fire_l_req, fire_r_req, output fire_l_ack, fire_r_ack);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 = left, bit 1 = right.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // The pointer only moves on contention, so a lone requester never steals priority.
  always_comb begin
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
    else              gnt = req;
    ptr_d = ptr_q;
    if (advance && (req == 2'b11)) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/projectile_scheduler.sv
// Projectile slot table: allocates slots to turret fire requests and advances
// every live projectile once per frame, reporting edge retirements as hits.
module projectile_scheduler import proj_pkg::*; #(
  parameter int NUM_SLOTS = 4,
  parameter int STEP      = 1,
  parameter int PROJ_W    = 40,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = int'(SCREEN_X_MAX),
  parameter int L_X       = 90,
  parameter int L_Y       = 52,
  parameter int R_X       = 510,
  parameter int R_Y       = 425
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  projectile_scheduler_if.slave     fire,
  output logic [NUM_SLOTS-1:0]      slot_active,
  output logic [NUM_SLOTS-1:0]      slot_dir,
  output logic [NUM_SLOTS*10-1:0]   slot_x,
  output logic [NUM_SLOTS*10-1:0]   slot_y,
  output logic                      hit_l,
  output logic                      hit_r,
  output logic                      busy,
  output sched_state_t              state_dbg
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             run_pend_q, run_pend_d;
  logic             frame_prev_q, frame_prev_d;
  logic             ack_l_q, ack_l_d, ack_r_q, ack_r_d;
  proj_slot_t       slots_q [NUM_SLOTS];
  proj_slot_t       slots_d [NUM_SLOTS];

  logic             tick, any_free, grant_ok, hit_l_c, hit_r_c;
  logic [IDX_W-1:0] free_idx;
  logic [1:0]       arb_req, gnt;

  assign frame_prev_d = frame_clk;
  assign tick         = frame_clk & ~frame_prev_q;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].active) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // A side whose ack is on the wire this cycle is masked so its still-high req is not re-granted.
  assign arb_req  = {fire.fire_r_req & ~ack_r_q, fire.fire_l_req & ~ack_l_q};
  assign grant_ok = (state_q == IDLE) && any_free;

  rr_arbiter2 u_arb (
    .clk     (vga_clk),
    .rst     (Reset),
    .req     (arb_req),
    .advance (grant_ok),
    .gnt     (gnt)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    run_pend_d = run_pend_q;
    slots_d    = slots_q;
    ack_l_d    = 1'b0;
    ack_r_d    = 1'b0;
    hit_l_c    = 1'b0;
    hit_r_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_ok && gnt[0]) begin
          slots_d[free_idx] = '{active: 1'b1, dir: DIR_POS, x: 10'(L_X), y: 10'(L_Y)};
          ack_l_d = 1'b1;
        end else if (grant_ok && gnt[1]) begin
          slots_d[free_idx] = '{active: 1'b1, dir: DIR_NEG, x: 10'(R_X), y: 10'(R_Y)};
          ack_r_d = 1'b1;
        end
        if (tick || pend_q) begin
          state_d    = UPDATE;
          idx_d      = '0;
          run_pend_d = pend_q;
        end
      end
      UPDATE: begin
        pend_d = pend_q | tick;
        if (slots_q[idx_q].active) begin
          if (slots_q[idx_q].dir == DIR_POS) begin
            if (({1'b0, slots_q[idx_q].x} + 11'(STEP) + 11'(PROJ_W)) > 11'(X_MAX)) begin
              slots_d[idx_q].active = 1'b0;
              hit_r_c = 1'b1;
            end else begin
              slots_d[idx_q].x = slots_q[idx_q].x + 10'(STEP);
            end
          end else begin
            if ({1'b0, slots_q[idx_q].x} < 11'(X_MIN + STEP)) begin
              slots_d[idx_q].active = 1'b0;
              hit_l_c = 1'b1;
            end else begin
              slots_d[idx_q].x = slots_q[idx_q].x - 10'(STEP);
            end
          end
        end
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      DONE: begin
        // A pass launched from pend consumes it; otherwise a pend raised during this pass survives.
        pend_d     = run_pend_q ? 1'b0 : (pend_q | tick);
        run_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      run_pend_q   <= 1'b0;
      frame_prev_q <= 1'b0;
      ack_l_q      <= 1'b0;
      ack_r_q      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      run_pend_q   <= run_pend_d;
      frame_prev_q <= frame_prev_d;
      ack_l_q      <= ack_l_d;
      ack_r_q      <= ack_r_d;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
    end
  end

  always_comb begin
    slot_active = '0;
    slot_dir    = '0;
    slot_x      = '0;
    slot_y      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_active[i]      = slots_q[i].active;
      slot_dir[i]         = slots_q[i].dir;
      slot_x[10*i +: 10]  = slots_q[i].x;
      slot_y[10*i +: 10]  = slots_q[i].y;
    end
  end

  assign fire.fire_l_ack = ack_l_q;
  assign fire.fire_r_ack = ack_r_q;
  assign hit_l     = hit_l_c & ~Reset;
  assign hit_r     = hit_r_c & ~Reset;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_projectile_scheduler.sv
// Bench for projectile_scheduler: directed steps plus randomized fire/tick traffic
// checked against a slot-table model kept in plain arrays.
module tb_projectile_scheduler;
  import proj_pkg::*;

  localparam int NS     = 4;
  localparam int STEP   = 1;
  localparam int PROJ_W = 40;
  localparam int X_MIN  = 10;
  localparam int X_MAX  = 639;

  logic            vga_clk = 1'b0;
  logic            Reset;
  logic            frame_clk;
  logic [NS-1:0]   slot_active, slot_dir;
  logic [NS*10-1:0] slot_x, slot_y;
  logic            hit_l, hit_r, busy;
  sched_state_t    state_dbg;

  projectile_scheduler_if fire_bus ();

  projectile_scheduler dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .fire        (fire_bus),
    .slot_active (slot_active),
    .slot_dir    (slot_dir),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .hit_l       (hit_l),
    .hit_r       (hit_r),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0;
  int bad   = 0;

  // Reference slot table
  int m_act [NS];
  int m_dir [NS];
  int m_x   [NS];
  int m_y   [NS];
  bit m_ptr;
  bit hold_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_ptr = 1'b0;
  endfunction

  function automatic int m_free_count();
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_act[i] == 0) n++;
    return n;
  endfunction

  function automatic void m_alloc(input bit side);
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] == 0) begin
        m_act[i] = 1;
        m_dir[i] = side;
        m_x[i]   = side ? 510 : 90;
        m_y[i]   = side ? 425 : 52;
        return;
      end
    end
  endfunction

  // One frame of motion; hl/hr[i+1] flag a retirement of slot i
  function automatic void m_pass(output logic [7:0] hl, output logic [7:0] hr);
    hl = '0; hr = '0;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0) begin
        if (m_dir[i] == 0) begin
          if (m_x[i] + STEP + PROJ_W > X_MAX) begin m_act[i] = 0; hr[i+1] = 1'b1; end
          else m_x[i] = m_x[i] + STEP;
        end else begin
          if (m_x[i] < X_MIN + STEP) begin m_act[i] = 0; hl[i+1] = 1'b1; end
          else m_x[i] = m_x[i] - STEP;
        end
      end
    end
  endfunction

  task automatic check_table();
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("slot%0d_active", i), slot_active[i], m_act[i]);
      if (m_act[i] != 0) begin
        chk($sformatf("slot%0d_dir", i), slot_dir[i], m_dir[i]);
        chk($sformatf("slot%0d_x", i), slot_x[10*i +: 10], m_x[i]);
        chk($sformatf("slot%0d_y", i), slot_y[10*i +: 10], m_y[i]);
      end
    end
  endtask

  task automatic fire_one(input bit side);
    if (side) fire_bus.fire_r_req = 1'b1; else fire_bus.fire_l_req = 1'b1;
    @(negedge vga_clk);
    chk("ack_latency", side ? fire_bus.fire_r_ack : fire_bus.fire_l_ack, 1);
    chk("ack_other", side ? fire_bus.fire_l_ack : fire_bus.fire_r_ack, 0);
    m_alloc(side);
    @(negedge vga_clk);
    chk("ack_single", side ? fire_bus.fire_r_ack : fire_bus.fire_l_ack, 0);
    fire_bus.fire_l_req = 1'b0;
    fire_bus.fire_r_req = 1'b0;
    check_table();
  endtask

  task automatic fire_both();
    bit w;
    w = m_ptr;
    fire_bus.fire_l_req = 1'b1;
    fire_bus.fire_r_req = 1'b1;
    @(negedge vga_clk);
    chk("both_first_l", fire_bus.fire_l_ack, w == 1'b0);
    chk("both_first_r", fire_bus.fire_r_ack, w == 1'b1);
    m_alloc(w);
    m_ptr = ~m_ptr;
    @(negedge vga_clk);
    chk("both_second_l", fire_bus.fire_l_ack, w == 1'b1);
    chk("both_second_r", fire_bus.fire_r_ack, w == 1'b0);
    m_alloc(~w);
    if (w) fire_bus.fire_r_req = 1'b0; else fire_bus.fire_l_req = 1'b0;
    @(negedge vga_clk);
    fire_bus.fire_l_req = 1'b0;
    fire_bus.fire_r_req = 1'b0;
    chk("both_after_l", fire_bus.fire_l_ack, 0);
    chk("both_after_r", fire_bus.fire_r_ack, 0);
    check_table();
  endtask

  task automatic do_tick();
    logic [7:0] ehl, ehr;
    frame_clk = 1'b1;
    m_pass(ehl, ehr);
    for (int k = 1; k <= 6; k++) begin
      @(negedge vga_clk);
      if (k == 1) frame_clk = 1'b0;
      chk("pass_busy", busy, k <= 5);
      chk("pass_hit_r", hit_r, (k <= 4) ? ehr[k] : 1'b0);
      chk("pass_hit_l", hit_l, (k <= 4) ? ehl[k] : 1'b0);
      chk("pass_ack_l", fire_bus.fire_l_ack, 0);
      chk("pass_ack_r", fire_bus.fire_r_ack, 0);
    end
    if (hold_r) begin
      @(negedge vga_clk);
      if (m_free_count() > 0) begin
        chk("held_ack", fire_bus.fire_r_ack, 1);
        m_alloc(1'b1);
        fire_bus.fire_r_req = 1'b0;
        hold_r = 1'b0;
      end else begin
        chk("held_noack", fire_bus.fire_r_ack, 0);
      end
    end
    check_table();
  endtask

  task automatic run_ticks(input int n, input bit rnd);
    int nf;
    for (int t = 0; t < n; t++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 3)) @(negedge vga_clk);
        if (!hold_r && $urandom_range(0, 2) == 0) begin
          nf = m_free_count();
          if (nf >= 2 && $urandom_range(0, 1) == 1) fire_both();
          else if (nf >= 1) fire_one(1'($urandom_range(0, 1)));
        end
      end
      do_tick();
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (3) @(negedge vga_clk);
    Reset = 1'b0;
    @(negedge vga_clk);
    m_reset();
  endtask

  initial begin
    int   rises;
    logic prev_busy;
    logic [7:0] dl, dr;

    Reset = 1'b1;
    frame_clk = 1'b0;
    fire_bus.fire_l_req = 1'b0;
    fire_bus.fire_r_req = 1'b0;
    hold_r = 1'b0;
    m_reset();

    // Reset state
    apply_reset();
    chk("rst_active", slot_active, 0);
    chk("rst_dir", slot_dir, 0);
    chk("rst_x", slot_x, 0);
    chk("rst_y", slot_y, 0);
    chk("rst_hit_l", hit_l, 0);
    chk("rst_hit_r", hit_r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack_l", fire_bus.fire_l_ack, 0);
    chk("rst_ack_r", fire_bus.fire_r_ack, 0);
    chk("rst_state", state_dbg, IDLE);

    // Lone left, then lone right
    fire_one(1'b0);
    chk("left_x0", slot_x[9:0], 90);
    chk("left_y0", slot_y[9:0], 52);
    chk("left_dir0", slot_dir[0], 0);
    fire_one(1'b1);
    chk("right_x1", slot_x[19:10], 510);
    chk("right_y1", slot_y[19:10], 425);

    // Ticks 2 apart use pend; a third during the second pass is dropped
    rises = 0;
    prev_busy = busy;
    for (int c = 0; c < 30; c++) begin
      frame_clk = (c == 0 || c == 2 || c == 8);
      @(negedge vga_clk);
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    frame_clk = 1'b0;
    chk("pend_passes", rises, 2);
    m_pass(dl, dr);
    m_pass(dl, dr);
    check_table();

    // Reset in the middle of an UPDATE pass
    frame_clk = 1'b1;
    @(negedge vga_clk);
    frame_clk = 1'b0;
    @(negedge vga_clk);
    chk("mid_busy_before", busy, 1);
    Reset = 1'b1;
    @(negedge vga_clk);
    chk("mid_rst_active", slot_active, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack_l", fire_bus.fire_l_ack, 0);
    chk("mid_rst_ack_r", fire_bus.fire_r_ack, 0);
    Reset = 1'b0;
    @(negedge vga_clk);
    m_reset();

    // Contention in both pointer directions fills the table
    fire_both();
    fire_both();
    chk("full_active", slot_active, 4'hf);
    fire_bus.fire_r_req = 1'b1;
    hold_r = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge vga_clk);
      chk("full_no_ack", fire_bus.fire_r_ack, 0);
    end
    run_ticks(508, 1'b0);
    chk("held_served", hold_r, 0);
    chk("edge_x598", slot_x[9:0], 598);
    run_ticks(1, 1'b0);
    chk("edge_x599", slot_x[9:0], 599);
    chk("edge_alive", slot_active[0], 1);
    run_ticks(1, 1'b0);
    chk("edge_retired", slot_active[0], 0);
    fire_one(1'b0);
    chk("realloc_slot0", slot_active[0], 1);
    chk("realloc_x", slot_x[9:0], 90);

    // Two leftward slots one step apart at the left edge
    apply_reset();
    fire_one(1'b1);
    run_ticks(1, 1'b0);
    fire_one(1'b1);
    run_ticks(499, 1'b0);
    chk("left_edge_x10", slot_x[9:0], 10);
    chk("left_edge_x11", slot_x[19:10], 11);
    run_ticks(1, 1'b0);
    chk("left_edge_gone", slot_active[0], 0);
    chk("left_edge_stay", slot_active[1], 1);
    chk("left_edge_move", slot_x[19:10], 10);

    // Random fire/tick traffic
    run_ticks(600, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
